// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single SRAM-like bus port between fetch and load/store.
// Two-phase access (address then data), data-side priority, flush cancel/discard.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    D_ADDR,
    D_DATA,
    I_ADDR,
    I_DATA
  } state_e;

  state_e      state_q, state_d;
  logic        discard_q, discard_d;
  logic        bus_wr_q, bus_wr_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  // Next-state, bus request and completion decode
  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    bus_wr_d    = bus_wr_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_req     = 1'b0;
    i_done      = 1'b0;
    d_done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!flush) begin
          if (d_req) begin
            state_d     = D_ADDR;
            bus_wr_d    = d_wr;
            bus_sel_d   = d_sel;
            bus_addr_d  = d_addr;
            bus_wdata_d = d_wdata;
          end else if (i_req) begin
            state_d     = I_ADDR;
            bus_wr_d    = 1'b0;
            bus_sel_d   = 4'b0000;
            bus_addr_d  = i_addr;
            bus_wdata_d = 32'h0;
          end
        end
      end
      D_ADDR, I_ADDR: begin
        bus_req = 1'b1;
        if (bus_addr_ok) begin
          state_d   = (state_q == D_ADDR) ? D_DATA : I_DATA;
          discard_d = flush;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      D_DATA, I_DATA: begin
        if (bus_data_ok) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          if (!discard_q && !flush) begin
            d_done = (state_q == D_DATA);
            i_done = (state_q == I_DATA);
          end
        end else begin
          discard_d = discard_q | flush;
        end
      end
      default: begin
        state_d   = IDLE;
        discard_d = 1'b0;
      end
    endcase
  end

  // Read data: live bus data in the done cycle, else the last completed word
  always_comb begin
    i_rdata_d = i_done ? bus_rdata : i_rdata_q;
    d_rdata_d = d_done ? bus_rdata : d_rdata_q;
  end

  assign i_rdata   = i_rdata_d;
  assign d_rdata   = d_rdata_d;
  assign i_stall   = i_req & ~i_done;
  assign d_stall   = d_req & ~d_done;
  assign bus_wr    = bus_wr_q;
  assign bus_sel   = bus_sel_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

  // State, discard flag, bus command and read-data hold registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      discard_q   <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_sel_q   <= 4'b0000;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      i_rdata_q   <= 32'h0;
      d_rdata_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      bus_wr_q    <= bus_wr_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter.
// Bus responder with programmable address/data wait states.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        i_req, d_req, d_wr;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_sel;
  logic [31:0] i_rdata, d_rdata;
  logic        i_done, i_stall, d_done, d_stall;
  logic        bus_req, bus_wr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_done     (i_done),
    .i_stall    (i_stall),
    .d_req      (d_req),
    .d_wr       (d_wr),
    .d_sel      (d_sel),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_done     (d_done),
    .d_stall    (d_stall),
    .bus_req    (bus_req),
    .bus_wr     (bus_wr),
    .bus_sel    (bus_sel),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok),
    .bus_rdata  (bus_rdata)
  );

  typedef struct {
    logic        side;
    logic [31:0] data;
    int          cyc;
  } done_t;

  typedef struct {
    logic        wr;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } bus_t;

  done_t sb[$];
  bus_t  bq[$];

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int aw = 0, dw = 0, acnt = 0, dcnt = 0;
  bit in_data = 1'b0;
  logic [31:0] cur_rd = 32'h0;
  logic s_istall, s_busreq, s_idone, s_ddone;
  logic [3:0] s_sel;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] rd);
    i_req  = 1'b1;
    i_addr = a;
    bq.push_back('{wr: 1'b0, sel: 4'b0, addr: a, wdata: 32'h0, rdata: rd});
    sb.push_back('{side: 1'b0, data: rd, cyc: cyc_n + 2 + aw + dw});
  endtask

  task automatic daccess(input logic wr, input logic [3:0] sel,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd);
    d_req   = 1'b1;
    d_wr    = wr;
    d_sel   = sel;
    d_addr  = a;
    d_wdata = wd;
    bq.push_back('{wr: wr, sel: sel, addr: a, wdata: wd, rdata: rd});
    sb.push_back('{side: 1'b1, data: rd, cyc: cyc_n + 2 + aw + dw});
  endtask

  // One clock cycle: called at posedge+1 with this cycle's inputs applied
  task automatic tick();
    done_t e;
    bus_t  b;
    bus_addr_ok = bus_req && (acnt >= aw);
    bus_data_ok = in_data && (dcnt >= dw);
    bus_rdata   = cur_rd;
    @(negedge clk);
    s_istall = i_stall;
    s_busreq = bus_req;
    s_sel    = bus_sel;
    s_idone  = i_done;
    s_ddone  = d_done;
    if (i_done || d_done) begin
      if (sb.size() == 0) begin
        chk("unexp_done", 32'({i_done, d_done}), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("done_side", 32'(d_done), 32'(e.side));
        chk("rdata", d_done ? d_rdata : i_rdata, e.data);
        chk("done_cyc", 32'(cyc_n), 32'(e.cyc));
      end
    end
    if (bus_req) begin
      if (bq.size() == 0) begin
        chk("unexp_req", 32'(bus_req), 32'h0);
      end else begin
        b = bq[0];
        chk("bus_addr", bus_addr, b.addr);
        chk("bus_sel", 32'(bus_sel), 32'(b.sel));
        chk("bus_wr", 32'(bus_wr), 32'(b.wr));
        if (b.wr) chk("bus_wdata", bus_wdata, b.wdata);
        if (bus_addr_ok) begin
          cur_rd = b.rdata;
          void'(bq.pop_front());
        end else if (flush) begin
          void'(bq.pop_front());
        end
      end
    end
    if (in_data) begin
      if (bus_data_ok) in_data = 1'b0;
      else dcnt++;
    end
    if (bus_req && bus_addr_ok) begin
      in_data = 1'b1;
      dcnt    = 0;
    end
    if (bus_req && !bus_addr_ok) acnt++;
    else acnt = 0;
    @(posedge clk);
    #1;
    if (s_idone) i_req = 1'b0;
    if (s_ddone) d_req = 1'b0;
    cyc_n++;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout", 32'(sb.size()), 32'h0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; d_sel = 4'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_bus_wr", 32'(bus_wr), 32'h0);
    chk("rst_bus_sel", 32'(bus_sel), 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_dones", 32'({i_done, d_done}), 32'h0);
    i_req = 1'b1; d_req = 1'b1;
    #1;
    chk("rst_stalls", 32'({i_stall, d_stall}), 32'h3);
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single fetch, ideal bus
    cyc_n = 0;
    fetch(32'hBFC00000, 32'h24080001);
    tick();
    chk("t1_stall_c0", 32'(s_istall), 32'h1);
    chk("t1_breq_c0", 32'(s_busreq), 32'h0);
    tick();
    chk("t1_stall_c1", 32'(s_istall), 32'h1);
    chk("t1_breq_c1", 32'(s_busreq), 32'h1);
    tick();
    chk("t1_stall_c2", 32'(s_istall), 32'h0);
    drain(20);

    // store with address and data wait states
    aw = 2; dw = 3; cyc_n = 0;
    daccess(1'b1, 4'b0100, 32'h80000006, 32'h5A5A5A5A, 32'h000000A5);
    drain(30);
    chk("t2_sel_hold", 32'(s_sel), 32'h4);
    aw = 0; dw = 0;

    // simultaneous fetch and load
    cyc_n = 0;
    i_req = 1'b1; i_addr = 32'hBFC00004;
    d_req = 1'b1; d_wr = 1'b0; d_sel = 4'b0; d_addr = 32'h80001000;
    bq.push_back('{wr: 1'b0, sel: 4'b0, addr: 32'h80001000,
                   wdata: 32'h0, rdata: 32'h12345678});
    bq.push_back('{wr: 1'b0, sel: 4'b0, addr: 32'hBFC00004,
                   wdata: 32'h0, rdata: 32'h3C1D8000});
    sb.push_back('{side: 1'b1, data: 32'h12345678, cyc: 2});
    sb.push_back('{side: 1'b0, data: 32'h3C1D8000, cyc: 5});
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("t3_istall", 32'(s_istall), 32'(c < 5));
      chk("t3_breq", 32'(s_busreq), 32'(c == 1 || c == 4));
    end
    drain(10);

    // flush while the address phase is stalled
    aw = 5; cyc_n = 0;
    i_req = 1'b1; i_addr = 32'h00000100;
    bq.push_back('{wr: 1'b0, sel: 4'b0, addr: 32'h00000100,
                   wdata: 32'h0, rdata: 32'hFFFF0000});
    tick();
    tick();
    flush = 1'b1; i_req = 1'b0;
    tick();
    flush = 1'b0;
    tick();
    chk("t4_breq", 32'(s_busreq), 32'h0);
    chk("t4_rdata", i_rdata, 32'h3C1D8000);
    chk("t4_bq", 32'(bq.size()), 32'h0);
    aw = 0;

    // flush during the data phase
    dw = 2; cyc_n = 0;
    i_req = 1'b1; i_addr = 32'h00000104;
    bq.push_back('{wr: 1'b0, sel: 4'b0, addr: 32'h00000104,
                   wdata: 32'h0, rdata: 32'hDEADBEEF});
    tick();
    tick();
    flush = 1'b1; i_req = 1'b0;
    tick();
    flush = 1'b0;
    tick();
    tick();
    chk("t5_rdata", i_rdata, 32'h3C1D8000);
    chk("t5_in_data", 32'(in_data), 32'h0);
    dw = 0;
    fetch(32'h00000108, 32'h11112222);
    drain(10);

    // reset in the middle of a load's data phase
    dw = 5; cyc_n = 0;
    daccess(1'b0, 4'b0, 32'h80002000, 32'h0, 32'h55AA55AA);
    tick();
    tick();
    tick();
    rst = 1'b1;
    sb.delete();
    in_data = 1'b0;
    dcnt = 0;
    #1;
    chk("t6_breq", 32'(bus_req), 32'h0);
    chk("t6_ddone", 32'(d_done), 32'h0);
    chk("t6_dstall", 32'(d_stall), 32'h1);
    chk("t6_d_rdata", d_rdata, 32'h0);
    chk("t6_i_rdata", i_rdata, 32'h0);
    chk("t6_bus_addr", bus_addr, 32'h0);
    chk("t6_bus_sel", 32'(bus_sel), 32'h0);
    tick();
    rst = 1'b0;
    dw = 0; cyc_n = 0;
    daccess(1'b0, 4'b0, 32'h80002000, 32'h0, 32'h55AA55AA);
    drain(10);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    chk("bq_empty", 32'(bq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
